// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// The control bundle is ordered as the stage enables, then bubbles, flush and stall.
package hazard_pkg;

    typedef enum logic {
        S_RUN,
        S_MUL
    } state_e;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic if_id_flush;
        logic is_stall;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = 9'b11111_000_0;
    localparam ctrl_t CTRL_FREEZE = 9'b00000_000_1;
    localparam ctrl_t CTRL_MUL    = 9'b00011_010_1;
    localparam ctrl_t CTRL_BRANCH = 9'b11111_101_0;
    localparam ctrl_t CTRL_DATA   = 9'b00111_100_1;

endpackage

// File: rtl/hazard_raw_cmp.sv
// Read-after-write match of the ID sources against one producer stage.
// x0 is hardwired to zero and never creates a dependency.
module hazard_raw_cmp
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  wr_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    output logic                  hit_o
);

    logic rd_nz;

    assign rd_nz = (rd_i != REG_ADDR_W'(REG_ZERO));

    assign hit_o = wr_i & rd_nz &
                   ((use_rs1_i & (rs1_i == rd_i)) |
                    (use_rs2_i & (rs2_i == rd_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: memory freeze, multi-cycle EX occupancy,
// branch flush and RAW stalls, with saturating stall/flush counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FORWARDING = 1,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_is_mul,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  mem_wb_write,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  if_id_flush,
    output logic                  is_stall,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int MC_W = $clog2(MUL_LAT + 1);
    localparam logic [MC_W-1:0] MUL_INIT =
        (MUL_LAT > 2) ? MC_W'(MUL_LAT - 2) : '0;

    state_e           state_q, state_d;
    logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    ctrl_t            ctrl;
    logic             flush_inc;
    logic             mem_freeze;
    logic             ex_wr;
    logic             ex_hit;
    logic             mem_hit;
    logic             data_stall;

    assign mem_freeze = dmem_req & ~dmem_ready;
    assign ex_wr = (FORWARDING != 0) ? ex_mem_read : ex_reg_write;

    hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_ex_cmp (
        .rd_i      (ex_rd),
        .wr_i      (ex_wr),
        .rs1_i     (id_rs1),
        .rs2_i     (id_rs2),
        .use_rs1_i (id_use_rs1),
        .use_rs2_i (id_use_rs2),
        .hit_o     (ex_hit)
    );

    hazard_raw_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_mem_cmp (
        .rd_i      (mem_rd),
        .wr_i      (mem_reg_write),
        .rs1_i     (id_rs1),
        .rs2_i     (id_rs2),
        .use_rs1_i (id_use_rs1),
        .use_rs2_i (id_use_rs2),
        .hit_o     (mem_hit)
    );

    // With full bypass only the load in EX can't be forwarded in time.
    assign data_stall = ex_hit | ((FORWARDING == 0) & mem_hit);

    always_comb begin
        ctrl      = CTRL_RUN;
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        flush_inc = 1'b0;
        if (reset) begin
            ctrl = CTRL_RUN;
        end else if (mem_freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (state_q == S_MUL) begin
            ctrl      = CTRL_MUL;
            mul_cnt_d = mul_cnt_q - MC_W'(1);
            if (mul_cnt_q <= MC_W'(1)) begin
                state_d = S_RUN;
            end
        end else if (ex_is_mul && (MUL_LAT > 1)) begin
            ctrl = CTRL_MUL;
            if (MUL_LAT > 2) begin
                state_d   = S_MUL;
                mul_cnt_d = MUL_INIT;
            end
        end else if (ex_branch_taken) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
        end else if (data_stall) begin
            ctrl = CTRL_DATA;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (ctrl.is_stall && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RUN;
            mul_cnt_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign id_ex_write   = ctrl.id_ex_write;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign mem_wb_write  = ctrl.mem_wb_write;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign if_id_flush   = ctrl.if_id_flush;
    assign is_stall      = ctrl.is_stall;
    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline. Generalises load-use detection:
  - register-address width parameter;
  - forwarding-present / no-forwarding mode;
  - multi-cycle multiplier occupancy;
  - variable-latency data-memory freeze;
  - taken-branch flush;
  - saturating stall/flush performance counters.
- Sits beside the pipeline registers and drives every stage's write-enable, bubble and flush control.

Parameters:
- REG_ADDR_W, 5, register-index width.
- FORWARDING, 1, 1 = full EX/MEM bypass present (stall on load-use only); 0 = no bypass (stall on any RAW against EX or MEM).
- MUL_LAT, 3, total cycles a mul/div occupies EX (≥1).
- CNT_W, 16, perf-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  REG_ADDR_W  destination in EX
- ex_reg_write, ex_mem_read  in  1  EX writes the register file / EX is a load
- ex_is_mul  in  1  EX holds a multi-cycle op, first cycle
- mem_rd  in  REG_ADDR_W  destination in MEM
- mem_reg_write  in  1  MEM writes the register file
- dmem_req, dmem_ready  in  1  MEM-stage access pending / data memory completes this cycle
- ex_branch_taken  in  1  EX resolved a redirect
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  stage-register enables
- id_ex_bubble, ex_mem_bubble  out  1  insert NOP into ID/EX or EX/MEM
- if_id_flush  out  1  squash the IF/ID register
- is_stall  out  1  any stall this cycle
- stall_cycles, flush_count  out  CNT_W  saturating perf counters

Behaviour:
- State: S_RUN, S_MUL; mul_cnt register is ceil(log2(MUL_LAT+1)) bits.
- Reset (sync): state = S_RUN, mul_cnt = 0, both counters = 0.
  - While reset is high, outputs are forced to run values: all writes 1, bubbles/flush 0, is_stall 0.
- Condition mem_freeze = dmem_req & ~dmem_ready.
- Condition raw_hit(rd, wr) = wr & rd≠0 & ((id_use_rs1 & id_rs1=rd) | (id_use_rs2 & id_rs2=rd)). x0 never hazards.
- Condition data_stall:
  - FORWARDING=1: raw_hit(ex_rd, ex_mem_read).
  - FORWARDING=0: raw_hit(ex_rd, ex_reg_write) | raw_hit(mem_rd, mem_reg_write).
- Priority 1, mem_freeze:
  - All five writes = 0; no bubbles, no flush; is_stall = 1.
  - FSM and mul_cnt hold; branch and data hazards are ignored this cycle.
- Priority 2, S_MUL:
  - pc_write, if_id_write, id_ex_write = 0; ex_mem_bubble = 1; ex_mem_write, mem_wb_write = 1; is_stall = 1.
  - mul_cnt decrements; when mul_cnt = 1, next state is S_RUN.
  - ex_branch_taken is ignored in S_MUL.
- Priority 3, S_RUN with ex_is_mul and MUL_LAT > 1:
  - Same outputs as S_MUL.
  - Next state S_MUL with mul_cnt = MUL_LAT-2.
  - If MUL_LAT = 2: stall this cycle only and stay in S_RUN.
  - If MUL_LAT = 1: no stall.
- Priority 4, ex_branch_taken:
  - pc_write = 1 (redirect), if_id_flush = 1, id_ex_bubble = 1; other writes 1.
  - data_stall is suppressed (the ID instruction is dead).
  - is_stall = 0; flush_count increments.
- Priority 5, data_stall:
  - pc_write = 0, if_id_write = 0, id_ex_bubble = 1; other writes 1; is_stall = 1.
- Otherwise: all writes 1, bubbles/flush 0.
- stall_cycles increments on every cycle with is_stall = 1.
- Both counters saturate at all-ones and never wrap.
- All outputs except the counters are combinational from state + inputs. Counters and FSM update on rising clk.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum {S_RUN, S_MUL};
  - constant REG_ZERO = 0;
  - a struct bundling the stage-enable outputs.
- Sub-module hazard_raw_cmp: combinational raw_hit for one producer. Instantiate once for EX and once for MEM; the MEM instance is only used when FORWARDING=0.

Test Plan:
- FORWARDING=1:
  - ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 for 1 cycle; stall_cycles=1.
  - Same with ex_rd=0 -> no stall.
  - Same with id_use_rs2=0 -> no stall.
- FORWARDING=0: mem_reg_write=1, mem_rd=7, id_rs1=7 -> stall.
  - Same with FORWARDING=1 -> no stall.
- MUL_LAT=3: ex_is_mul pulse -> exactly 2 cycles with pc_write=0 and ex_mem_bubble=1, then run.
  - Pulse in the cycle after the return to S_RUN -> another 2-cycle stall.
- dmem_req=1, dmem_ready=0 for 4 cycles during S_MUL -> all writes 0 for those 4 cycles; mul stall resumes with mul_cnt unchanged; stall_cycles +6 total.
- Simultaneous: ex_branch_taken=1 with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall; flush_count=1.
- Reset asserted mid-S_MUL -> next cycle state S_RUN, counters 0. With CNT_W=4, a 20-cycle freeze ends with stall_cycles=15 (saturated).
